// File: rtl/rr_mem_controller.sv
// Round-robin arbiter of NUM_CONSUMERS read/write requesters onto NUM_CHANNELS memory channels.
// One-cycle grant-to-mem_valid and mem_ready-to-consumer_ready latency; requesters beyond free channels simply wait.
module rr_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
  output logic [NUM_CHANNELS-1:0]            channels_busy
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state            [NUM_CHANNELS];
  state_t                   state_next       [NUM_CHANNELS];
  logic [CW-1:0]            current_consumer [NUM_CHANNELS];
  logic [CW-1:0]            grant_consumer   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  grant_read;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] claimed_next;
  logic [NUM_CONSUMERS-1:0] claim_new;
  logic [NUM_CONSUMERS-1:0] claim_drop;
  logic [CW-1:0]            rr_ptr;
  logic [CW-1:0]            rr_ptr_next;
  logic                     found;
  int                       scan;

  logic [NUM_CHANNELS-1:0]           mem_write_valid_q;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address_q;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data_q;
  logic [NUM_CONSUMERS-1:0]          consumer_write_ready_q;

  // Releases only take effect at the next edge, so a consumer leaving relay this
  // cycle is never re-granted in the same cycle by another channel.
  always_comb begin
    claim_new   = '0;
    claim_drop  = '0;
    rr_ptr_next = rr_ptr;
    grant       = '0;
    grant_read  = '0;
    found       = 1'b0;
    scan        = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_next[i]     = state[i];
      grant_consumer[i] = '0;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      found = 1'b0;
      case (state[i])
        IDLE: begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan = (int'(rr_ptr) + k) % NUM_CONSUMERS;
            if (!found && !claimed[scan] && !claim_new[scan] &&
                (consumer_read_valid[scan] || (WRITE_ENABLE && consumer_write_valid[scan]))) begin
              found             = 1'b1;
              grant[i]          = 1'b1;
              grant_read[i]     = consumer_read_valid[scan];
              grant_consumer[i] = CW'(scan);
              claim_new[scan]   = 1'b1;
              rr_ptr_next       = CW'((scan + 1) % NUM_CONSUMERS);
              state_next[i]     = consumer_read_valid[scan] ? READ_WAITING : WRITE_WAITING;
            end
          end
        end
        READ_WAITING:  if (mem_read_ready[i])  state_next[i] = READ_RELAYING;
        WRITE_WAITING: if (mem_write_ready[i]) state_next[i] = WRITE_RELAYING;
        READ_RELAYING: begin
          if (!consumer_read_valid[current_consumer[i]]) begin
            state_next[i]                  = IDLE;
            claim_drop[current_consumer[i]] = 1'b1;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[current_consumer[i]]) begin
            state_next[i]                  = IDLE;
            claim_drop[current_consumer[i]] = 1'b1;
          end
        end
        default: state_next[i] = IDLE;
      endcase
    end
    claimed_next = (claimed & ~claim_drop) | claim_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]            <= IDLE;
        current_consumer[i] <= '0;
      end
      claimed <= '0;
      rr_ptr  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i] <= state_next[i];
        if (grant[i]) current_consumer[i] <= grant_consumer[i];
      end
      claimed <= claimed_next;
      rr_ptr  <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_valid         <= '0;
      mem_read_address       <= '0;
      mem_write_valid_q      <= '0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      consumer_read_ready    <= '0;
      consumer_read_data     <= '0;
      consumer_write_ready_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (grant[i] && grant_read[i]) begin
          mem_read_valid[i] <= 1'b1;
          mem_read_address[i*ADDR_BITS +: ADDR_BITS] <=
            consumer_read_address[int'(grant_consumer[i])*ADDR_BITS +: ADDR_BITS];
        end
        if (grant[i] && !grant_read[i]) begin
          mem_write_valid_q[i] <= 1'b1;
          mem_write_address_q[i*ADDR_BITS +: ADDR_BITS] <=
            consumer_write_address[int'(grant_consumer[i])*ADDR_BITS +: ADDR_BITS];
          mem_write_data_q[i*DATA_BITS +: DATA_BITS] <=
            consumer_write_data[int'(grant_consumer[i])*DATA_BITS +: DATA_BITS];
        end
        if (state[i] == READ_WAITING && mem_read_ready[i]) begin
          mem_read_valid[i] <= 1'b0;
          consumer_read_data[int'(current_consumer[i])*DATA_BITS +: DATA_BITS] <=
            mem_read_data[i*DATA_BITS +: DATA_BITS];
          consumer_read_ready[current_consumer[i]] <= 1'b1;
        end
        if (state[i] == WRITE_WAITING && mem_write_ready[i]) begin
          mem_write_valid_q[i]                        <= 1'b0;
          consumer_write_ready_q[current_consumer[i]] <= 1'b1;
        end
        if (state[i] == READ_RELAYING && state_next[i] == IDLE)
          consumer_read_ready[current_consumer[i]] <= 1'b0;
        if (state[i] == WRITE_RELAYING && state_next[i] == IDLE)
          consumer_write_ready_q[current_consumer[i]] <= 1'b0;
      end
    end
  end

  // A read-only instance presents a write path that is permanently quiet.
  assign mem_write_valid      = WRITE_ENABLE ? mem_write_valid_q      : '0;
  assign mem_write_address    = WRITE_ENABLE ? mem_write_address_q    : '0;
  assign mem_write_data       = WRITE_ENABLE ? mem_write_data_q       : '0;
  assign consumer_write_ready = WRITE_ENABLE ? consumer_write_ready_q : '0;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) channels_busy[i] = (state[i] != IDLE);
  end

endmodule

// File: tb/tb_rr_mem_controller.sv
// Bench: 4-consumer/2-channel read-write instance against a queue-based pairing model,
// plus a 1-channel read-only instance with literal expectations.
module tb_rr_mem_controller;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NN = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NN-1:0] crv, cwv, crr, cwr;
  logic [NN*AB-1:0] cra, cwa;
  logic [NN*DB-1:0] cwd, crd;
  logic [NC-1:0] mrv, mrr, mwv, mwr, busy;
  logic [NC*AB-1:0] mra, mwa;
  logic [NC*DB-1:0] mrd, mwd;

  logic [NN-1:0] b_crv, b_cwv, b_crr, b_cwr;
  logic [NN*AB-1:0] b_cra, b_cwa;
  logic [NN*DB-1:0] b_cwd, b_crd;
  logic b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
  logic [AB-1:0] b_mra, b_mwa;
  logic [DB-1:0] b_mrd, b_mwd;

  rr_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NN), .NUM_CHANNELS(NC),
                      .WRITE_ENABLE(1'b1)) dut_a (
    .clk(clk), .reset(rst),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr),
    .channels_busy(busy));

  rr_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NN), .NUM_CHANNELS(1),
                      .WRITE_ENABLE(1'b0)) dut_b (
    .clk(clk), .reset(rst),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra), .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
    .channels_busy(b_busy));

  int total = 0;
  int bad = 0;

  // Model of instance A: which consumer each channel serves, and the expected outputs.
  int own [NC];
  bit relay [NC];
  bit is_rd [NC];
  int ptr;
  logic [NC-1:0] e_mrv, e_mwv;
  logic [NC*AB-1:0] e_mra, e_mwa;
  logic [NC*DB-1:0] e_mwd;
  logic [NN-1:0] e_crr, e_cwr;
  logic [NN*DB-1:0] e_crd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      own[i] = -1; relay[i] = 1'b0; is_rd[i] = 1'b0;
    end
    ptr = 0;
    e_mrv = '0; e_mwv = '0; e_mra = '0; e_mwa = '0; e_mwd = '0;
    e_crr = '0; e_cwr = '0; e_crd = '0;
  endtask

  // Free channels (ascending) are paired with unclaimed requesters in rotated order.
  task automatic model_step();
    int idle_ch[$];
    int elig[$];
    bit owned [NN];
    int j, c, n;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NN; k++) owned[k] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (own[i] >= 0) owned[own[i]] = 1'b1;
      else idle_ch.push_back(i);
    end
    for (int k = 0; k < NN; k++) begin
      j = (ptr + k) % NN;
      if (!owned[j] && (crv[j] || cwv[j])) elig.push_back(j);
    end
    for (int i = 0; i < NC; i++) begin
      if (own[i] >= 0) begin
        j = own[i];
        if (!relay[i]) begin
          if (is_rd[i] && mrr[i]) begin
            e_mrv[i] = 1'b0; e_crr[j] = 1'b1; e_crd[j*DB +: DB] = mrd[i*DB +: DB]; relay[i] = 1'b1;
          end else if (!is_rd[i] && mwr[i]) begin
            e_mwv[i] = 1'b0; e_cwr[j] = 1'b1; relay[i] = 1'b1;
          end
        end else if (is_rd[i] ? !crv[j] : !cwv[j]) begin
          if (is_rd[i]) e_crr[j] = 1'b0;
          else e_cwr[j] = 1'b0;
          own[i] = -1;
        end
      end
    end
    n = (idle_ch.size() < elig.size()) ? idle_ch.size() : elig.size();
    for (int k = 0; k < n; k++) begin
      c = idle_ch[k];
      j = elig[k];
      own[c] = j; relay[c] = 1'b0; is_rd[c] = crv[j];
      if (crv[j]) begin
        e_mrv[c] = 1'b1; e_mra[c*AB +: AB] = cra[j*AB +: AB];
      end else begin
        e_mwv[c] = 1'b1; e_mwa[c*AB +: AB] = cwa[j*AB +: AB]; e_mwd[c*DB +: DB] = cwd[j*DB +: DB];
      end
      ptr = (j + 1) % NN;
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0] e_busy;
    for (int i = 0; i < NC; i++) e_busy[i] = (own[i] >= 0);
    chk("mem_read_valid", 64'(mrv), 64'(e_mrv));
    chk("mem_read_address", 64'(mra), 64'(e_mra));
    chk("mem_write_valid", 64'(mwv), 64'(e_mwv));
    chk("mem_write_address", 64'(mwa), 64'(e_mwa));
    chk("mem_write_data", 64'(mwd), 64'(e_mwd));
    chk("consumer_read_ready", 64'(crr), 64'(e_crr));
    chk("consumer_read_data", 64'(crd), 64'(e_crd));
    chk("consumer_write_ready", 64'(cwr), 64'(e_cwr));
    chk("channels_busy", 64'(busy), 64'(e_busy));
    chk("ro mem_write_valid", 64'(b_mwv), 64'(0));
    chk("ro consumer_write_ready", 64'(b_cwr), 64'(0));
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  task automatic drive_random();
    int kind;
    for (int j = 0; j < NN; j++) begin
      if (crv[j] && e_crr[j]) crv[j] = 1'b0;
      if (cwv[j] && e_cwr[j]) cwv[j] = 1'b0;
      if (!crv[j] && !cwv[j] && !e_crr[j] && !e_cwr[j] && $urandom_range(0, 3) == 0) begin
        kind = int'($urandom_range(0, 2));
        crv[j] = (kind != 1);
        cwv[j] = (kind != 0);
        cra[j*AB +: AB] = AB'($urandom);
        cwa[j*AB +: AB] = AB'($urandom);
        cwd[j*DB +: DB] = DB'($urandom);
      end
    end
    for (int c = 0; c < NC; c++) begin
      mrr[c] = e_mrv[c] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mwr[c] = e_mwv[c] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mrd[c*DB +: DB] = DB'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0; mrr = '0; mwr = '0; mrd = '0;
    b_crv = '0; b_cwv = '0; b_cra = '0; b_cwa = '0; b_cwd = '0; b_mrr = 1'b0; b_mwr = 1'b0; b_mrd = '0;
    model_reset();
    tick();
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset mem_read_valid", 64'(mrv), 64'(0));
    rst = 1'b0;

    // Single read of 0x12, memory answers 0xBEEF three cycles later.
    crv[0] = 1'b1; cra[7:0] = 8'h12;
    tick();
    chk("t1 mrv", 64'(mrv), 64'(2'b01));
    chk("t1 mra", 64'(mra[7:0]), 64'(8'h12));
    tick(); tick();
    mrr[0] = 1'b1; mrd[15:0] = 16'hBEEF;
    tick();
    chk("t1 crr", 64'(crr), 64'(4'b0001));
    chk("t1 crd", 64'(crd[15:0]), 64'(16'hBEEF));
    mrr = '0; crv[0] = 1'b0;
    tick();
    chk("t1 crr clear", 64'(crr), 64'(0));
    chk("t1 busy clear", 64'(busy), 64'(0));
    chk("t1 crd hold", 64'(crd[15:0]), 64'(16'hBEEF));

    // Four simultaneous readers, zero-wait memory: c0,c1 then c2,c3 then c0,c1 again.
    do_reset();
    for (int j = 0; j < NN; j++) begin
      crv[j] = 1'b1; cra[j*AB +: AB] = 8'(8'hA0 + j);
    end
    tick();
    chk("t2 grant c0c1", 64'(mra), 64'(16'hA1A0));
    mrr = 2'b11;
    tick();
    chk("t2 crr c0c1", 64'(crr), 64'(4'b0011));
    mrr = '0; crv[1:0] = 2'b00;
    tick();
    chk("t2 released", 64'(mrv), 64'(0));
    crv[1:0] = 2'b11;
    tick();
    chk("t2 grant c2c3", 64'(mra), 64'(16'hA3A2));
    mrr = 2'b11;
    tick();
    chk("t2 crr c2c3", 64'(crr), 64'(4'b1100));
    mrr = '0; crv[3:2] = 2'b00;
    tick();
    tick();
    chk("t2 wrap c0c1", 64'(mra), 64'(16'hA1A0));
    chk("t2 wrap mrv", 64'(mrv), 64'(2'b11));
    mrr = 2'b11;
    tick();
    mrr = '0; crv = '0;
    tick();

    // c2 read 0x40 and write 0x41/0x00AA together: read first, write after relay.
    crv[2] = 1'b1; cra[23:16] = 8'h40;
    cwv[2] = 1'b1; cwa[23:16] = 8'h41; cwd[47:32] = 16'h00AA;
    tick();
    chk("t3 read first", 64'(mra[7:0]), 64'(8'h40));
    chk("t3 no write yet", 64'(mwv), 64'(0));
    mrr[0] = 1'b1; mrd[15:0] = 16'h1234;
    tick();
    chk("t3 crd", 64'(crd[47:32]), 64'(16'h1234));
    mrr = '0; crv[2] = 1'b0;
    tick();
    chk("t3 write waits relay", 64'(mwv), 64'(0));
    tick();
    chk("t3 mwv", 64'(mwv), 64'(2'b01));
    chk("t3 mwa", 64'(mwa[7:0]), 64'(8'h41));
    chk("t3 mwd", 64'(mwd[15:0]), 64'(16'h00AA));
    mwr[0] = 1'b1;
    tick();
    chk("t3 cwr", 64'(cwr), 64'(4'b0100));
    mwr = '0; cwv[2] = 1'b0;
    tick();

    // Reset mid-wait drops outputs at once; afterwards arbitration restarts at consumer 0.
    crv[1] = 1'b1; cra[15:8] = 8'h55;
    tick();
    chk("t4 waiting", 64'(busy), 64'(2'b01));
    #2;
    rst = 1'b1; crv = '0;
    #1;
    chk("t4 async mrv", 64'(mrv), 64'(0));
    chk("t4 async busy", 64'(busy), 64'(0));
    tick();
    rst = 1'b0;
    crv[1] = 1'b1; crv[3] = 1'b1; cra[31:24] = 8'h77;
    tick();
    chk("t4 ptr zero", 64'(mra), 64'(16'h7755));
    mrr = 2'b11;
    tick();
    mrr = '0; crv = '0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end
    crv = '0; cwv = '0; mrr = '0; mwr = '0;
    do_reset();

    // Read-only single-channel instance: c0 then c3, c1 write never served.
    b_cwv[1] = 1'b1; b_cwa[15:8] = 8'h21; b_cwd[31:16] = 16'h7777;
    b_crv[0] = 1'b1; b_cra[7:0] = 8'h30;
    b_crv[3] = 1'b1; b_cra[31:24] = 8'h33;
    tick();
    chk("ro grant c0", 64'(b_mra), 64'(8'h30));
    chk("ro mrv c0", 64'(b_mrv), 64'(1));
    b_mrr = 1'b1; b_mrd = 16'h5A5A;
    tick();
    chk("ro crr c0", 64'(b_crr), 64'(4'b0001));
    chk("ro crd c0", 64'(b_crd[15:0]), 64'(16'h5A5A));
    b_mrr = 1'b0; b_crv[0] = 1'b0;
    tick();
    chk("ro idle gap mrv", 64'(b_mrv), 64'(0));
    chk("ro idle gap busy", 64'(b_busy), 64'(0));
    tick();
    chk("ro grant c3", 64'(b_mra), 64'(8'h33));
    chk("ro mrv c3", 64'(b_mrv), 64'(1));
    b_mrr = 1'b1; b_mrd = 16'hC3C3;
    tick();
    chk("ro crd c3", 64'(b_crd[63:48]), 64'(16'hC3C3));
    b_mrr = 1'b0; b_crv[3] = 1'b0;
    tick();
    for (int n = 0; n < 14; n++) begin
      tick();
      chk("ro write ignored busy", 64'(b_busy), 64'(0));
    end
    chk("ro mwa", 64'(b_mwa), 64'(0));
    chk("ro mwd", 64'(b_mwd), 64'(0));
    b_cwv = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mem_controller.md
Name: rr_mem_controller

Overview:
Parametrised successor to the program/data memory controller. Arbitrates read and write requests from NUM_CONSUMERS fetchers or LSUs onto NUM_CHANNELS external memory channels. Arbitration is round-robin and fair. Writes can be compiled out for read-only program memory, and the block exposes busy status. It sits between the cores and global memory, one instance per memory (program, data).

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 16, data width (8 for data memory, 16 for program memory)
NUM_CONSUMERS, 4, number of requesters (>=2)
NUM_CHANNELS, 2, number of concurrent memory channels (1..NUM_CONSUMERS)
WRITE_ENABLE, 1, 0 = read-only; write path ignored and its outputs tied low

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request, held until ready seen, then dropped
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer j at [j*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read data valid
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write done
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_read_ready  in  NUM_CHANNELS  memory read done
mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_write_data  out  NUM_CHANNELS*DATA_BITS  packed
mem_write_ready  in  NUM_CHANNELS  memory write done
channels_busy  out  NUM_CHANNELS  1 when the channel state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs go to 0, all channels to IDLE, all consumer-claimed bits to 0, rr_ptr to 0.
  - In-flight memory transactions are abandoned; memory must tolerate a dropped valid.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE arbitration:
  - Each cycle, IDLE channels are processed in ascending channel index.
  - Each IDLE channel scans consumers from rr_ptr upward, modulo NUM_CONSUMERS.
  - It picks the first consumer j that is not claimed (including claims made this cycle by a lower channel) and has read_valid, or has write_valid with WRITE_ENABLE=1.
  - Read takes priority over write for the same consumer.
  - A grant sets claimed[j] and current_consumer[i]=j, and registers mem_*_valid/address/data on the next edge.
  - Next state is READ_WAITING or WRITE_WAITING.
  - When at least one grant occurs in a cycle, rr_ptr <= (highest-index-in-scan-order granted consumer + 1) mod NUM_CONSUMERS. Otherwise rr_ptr holds.
- Latency: request seen at edge N gives mem_*_valid high after edge N. Memory ready sampled at edge M gives the consumer ready (and read data) high after edge M.
- READ_WAITING: on mem_read_ready[i], the block drops mem_read_valid[i], latches the data into consumer_read_data[j], sets consumer_read_ready[j], and goes to READ_RELAYING.
- WRITE_WAITING: handled the same way with the write signals, then goes to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - When consumer valid[j] is low, the block clears ready[j] and claimed[j] and returns to IDLE.
  - The channel can grant again on the following cycle, never in the same cycle.
  - consumer_read_data holds its last value after ready drops.
- One consumer is served by at most one channel at a time. Requests from consumers beyond NUM_CHANNELS wait; starvation is impossible because of round-robin.
- WRITE_ENABLE=0: consumer_write_ready, mem_write_valid, mem_write_address and mem_write_data are constant 0; write requests never granted.
- Simultaneous read_valid and write_valid from one consumer: read served first, write served in a later grant after the relay completes.
- Memory ready while the channel is not waiting: ignored.

Test Plan:
- Single read, CONSUMERS=4, CHANNELS=2: c0 reads addr 0x12, memory returns 0xBEEF with ready after 3 cycles -> mem_read_valid[0] high 1 cycle after request; consumer_read_ready[0] high with data 0xBEEF 1 cycle after mem ready; ready clears 1 cycle after c0 drops valid; channels_busy back to 0.
- Four consumers read simultaneously, zero-wait memory -> grant order c0,c1 then c2,c3; repeat with all valid held -> next round starts at c0 again (rr_ptr wraps from 3 to 0); no consumer granted twice before the others.
- c2 asserts read(0x40) and write(0x41, data 0x00AA) together -> read completes first; the write is issued on mem_write_* with address 0x41 and data 0x00AA only after the read relay finishes.
- WRITE_ENABLE=0: c1 write_valid held 20 cycles -> mem_write_valid stays 0 and consumer_write_ready stays 0; concurrent c3 read completes normally.
- Reset asserted mid READ_WAITING, between clock edges -> mem_read_valid and channels_busy drop to 0 immediately; after release, a re-issued request is granted with rr_ptr=0.
- CHANNELS=1, c0 and c3 request: c0 served first; c3 granted the cycle after channel 0 returns to IDLE, not earlier.
